decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 212 +++++++++++++++++++++
 tb/tb_decode_stage.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//   Single-register RV32I decode stage. Decode is purely combinational from
//   instr_in; the decoded bundle is captured into one pipeline register on the
//   input handshake and presented to rename one cycle later.
//
// Ports
//   clk          clock, rising edge
//   reset        asynchronous active-low reset
//   instr_in     32-bit instruction from the fetch skid buffer
//   pc_in        PC of instr_in (PC_W bits)
//   valid_in     instr_in/pc_in valid
//   ready_in     decode can accept this cycle
//   flush        synchronous kill of held and arriving instruction
//   valid_out    decoded bundle valid toward rename
//   ready_out    rename accepts the bundle
//   pc_out, rs1, rs2, rd, imm, alu_op, fu_type, br_funct3, mem_funct3,
//   uses_rs1, uses_rs2, writes_rd, illegal   registered decoded bundle
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. valid_out never drops without an output transfer, a flush or a
// reset, and the bundle stays stable while valid_out=1 and ready_out=0.
// ---------------------------------------------------------------------------
module decode_stage #(
    parameter int PC_W = 9
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instr_in,
    input  logic [PC_W-1:0] pc_in,
    input  logic            valid_in,
    output logic            ready_in,
    input  logic            flush,
    output logic            valid_out,
    input  logic            ready_out,
    output logic [PC_W-1:0] pc_out,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [31:0]     imm,
    output logic [3:0]      alu_op,
    output logic [1:0]      fu_type,
    output logic [2:0]      br_funct3,
    output logic [2:0]      mem_funct3,
    output logic            uses_rs1,
    output logic            uses_rs2,
    output logic            writes_rd,
    output logic            illegal
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_LUI   = 4'd10;
    localparam logic [3:0] ALU_AUIPC = 4'd11;

    localparam logic [1:0] FU_ALU    = 2'd0;
    localparam logic [1:0] FU_BRANCH = 2'd1;
    localparam logic [1:0] FU_LOAD   = 2'd2;
    localparam logic [1:0] FU_STORE  = 2'd3;

    localparam int BW = PC_W + 60;

    // ---------------- combinational decode ----------------
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = instr_in[6:0];
    assign funct3 = instr_in[14:12];
    assign funct7 = instr_in[31:25];

    assign imm_i = {{20{instr_in[31]}}, instr_in[31:20]};
    assign imm_s = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
    assign imm_b = {{19{instr_in[31]}}, instr_in[31], instr_in[7], instr_in[30:25],
                    instr_in[11:8], 1'b0};
    assign imm_u = {instr_in[31:12], 12'b0};
    assign imm_j = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12], instr_in[20],
                    instr_in[30:21], 1'b0};

    logic [31:0] dec_imm;
    logic [3:0]  dec_alu;
    logic [1:0]  dec_fu;
    logic        dec_u1, dec_u2, dec_wr, dec_ill;
    logic [3:0]  f3_alu;

    // funct3 -> base ALU op shared by OP and OP-IMM; SUB/SRA are overlaid below.
    always_comb begin
        f3_alu = ALU_ADD;
        case (funct3)
            3'b000:  f3_alu = ALU_ADD;
            3'b001:  f3_alu = ALU_SLL;
            3'b010:  f3_alu = ALU_SLT;
            3'b011:  f3_alu = ALU_SLTU;
            3'b100:  f3_alu = ALU_XOR;
            3'b101:  f3_alu = ALU_SRL;
            3'b110:  f3_alu = ALU_OR;
            default: f3_alu = ALU_AND;
        endcase
    end

    always_comb begin
        dec_imm = '0;
        dec_alu = ALU_ADD;
        dec_fu  = FU_ALU;
        dec_u1  = 1'b0;
        dec_u2  = 1'b0;
        dec_wr  = 1'b0;
        dec_ill = 1'b0;
        case (opcode)
            OPC_LUI:    begin dec_imm = imm_u; dec_alu = ALU_LUI;   dec_wr = 1'b1; end
            OPC_AUIPC:  begin dec_imm = imm_u; dec_alu = ALU_AUIPC; dec_wr = 1'b1; end
            OPC_JAL:    begin dec_imm = imm_j; dec_fu = FU_BRANCH;  dec_wr = 1'b1; end
            OPC_JALR: begin
                dec_imm = imm_i; dec_fu = FU_BRANCH; dec_u1 = 1'b1; dec_wr = 1'b1;
            end
            OPC_BRANCH: begin
                dec_imm = imm_b; dec_fu = FU_BRANCH; dec_u1 = 1'b1; dec_u2 = 1'b1;
            end
            OPC_LOAD: begin
                dec_imm = imm_i; dec_fu = FU_LOAD; dec_u1 = 1'b1; dec_wr = 1'b1;
            end
            OPC_STORE: begin
                dec_imm = imm_s; dec_fu = FU_STORE; dec_u1 = 1'b1; dec_u2 = 1'b1;
            end
            OPC_OP_IMM: begin
                dec_imm = imm_i; dec_u1 = 1'b1; dec_wr = 1'b1;
                dec_alu = f3_alu;
                // Shift-immediate: SLLI needs a clean funct7, SRLI/SRAI pick on bit 30.
                if (funct3 == 3'b001 && funct7 != 7'b0000000) dec_ill = 1'b1;
                if (funct3 == 3'b101 && instr_in[30])          dec_alu = ALU_SRA;
            end
            OPC_OP: begin
                dec_u1 = 1'b1; dec_u2 = 1'b1; dec_wr = 1'b1;
                dec_alu = f3_alu;
                if (funct7 != 7'b0000000 && funct7 != 7'b0100000) dec_ill = 1'b1;
                if (funct7 == 7'b0100000 && funct3 == 3'b000) dec_alu = ALU_SUB;
                if (funct7 == 7'b0100000 && funct3 == 3'b101) dec_alu = ALU_SRA;
            end
            default: dec_ill = 1'b1;
        endcase
        // Illegal encodings still travel down the pipe, but as an inert ADD.
        if (dec_ill) begin
            dec_imm = '0;
            dec_alu = ALU_ADD;
            dec_fu  = FU_ALU;
            dec_u1  = 1'b0;
            dec_u2  = 1'b0;
            dec_wr  = 1'b0;
        end
        if (instr_in[11:7] == 5'd0) dec_wr = 1'b0;
    end

    // ---------------- pipeline register ----------------
    logic          valid_q, valid_d;
    logic [BW-1:0] bundle_q, bundle_d;
    logic          in_fire;
    logic [2:0]    funct3_q;

    // A flush frees the stage, so it may always accept (and then drop) input.
    assign ready_in = flush || !valid_q || ready_out;
    assign in_fire  = valid_in && ready_in && !flush;

    always_comb begin
        valid_d  = valid_q;
        bundle_d = bundle_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (in_fire) begin
            valid_d  = 1'b1;
            bundle_d = {pc_in, instr_in[19:15], instr_in[24:20], instr_in[11:7], dec_imm,
                        dec_alu, dec_fu, funct3, dec_u1, dec_u2, dec_wr, dec_ill};
        end else if (valid_q && ready_out) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
        end
    end

    assign valid_out = valid_q;
    assign {pc_out, rs1, rs2, rd, imm, alu_op, fu_type, funct3_q,
            uses_rs1, uses_rs2, writes_rd, illegal} = bundle_q;
    assign br_funct3  = funct3_q;
    assign mem_funct3 = funct3_q;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//   Directed and randomised stimulus for decode_stage. A queue-based model of
//   the one-entry stage plus a reference RV32I decoder predict every output;
//   a negedge compare process checks them each cycle.
// ---------------------------------------------------------------------------
module tb_decode_stage;

    localparam int PC_W = 9;
    localparam int W    = 32 + PC_W;

    logic            clk;
    logic            reset;
    logic [31:0]     instr_in;
    logic [PC_W-1:0] pc_in;
    logic            valid_in;
    logic            ready_in;
    logic            flush;
    logic            valid_out;
    logic            ready_out;
    logic [PC_W-1:0] pc_out;
    logic [4:0]      rs1, rs2, rd;
    logic [31:0]     imm;
    logic [3:0]      alu_op;
    logic [1:0]      fu_type;
    logic [2:0]      br_funct3, mem_funct3;
    logic            uses_rs1, uses_rs2, writes_rd, illegal;

    int checks   = 0;
    int failures = 0;
    int emitted  = 0;

    logic [W-1:0] exp_q[$];

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [1:0]  fu;
        logic [2:0]  f3;
        logic        u1;
        logic        u2;
        logic        wr;
        logic        ill;
    } dec_t;

    decode_stage #(.PC_W(PC_W)) dut (
        .clk(clk), .reset(reset), .instr_in(instr_in), .pc_in(pc_in),
        .valid_in(valid_in), .ready_in(ready_in), .flush(flush),
        .valid_out(valid_out), .ready_out(ready_out), .pc_out(pc_out),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .alu_op(alu_op),
        .fu_type(fu_type), .br_funct3(br_funct3), .mem_funct3(mem_funct3),
        .uses_rs1(uses_rs1), .uses_rs2(uses_rs2), .writes_rd(writes_rd),
        .illegal(illegal)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference decoder ----------------
    function automatic dec_t ref_decode(input logic [31:0] i);
        dec_t d;
        logic signed [31:0] t;
        logic [31:0] im_i, im_s, im_b, im_u, im_j;
        logic [3:0]  f3_tab [8];
        logic        writer;
        f3_tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        t = i;                                                   im_i = t >>> 20;
        t = {i[31:25], i[11:7], 20'b0};                          im_s = t >>> 20;
        t = {i[31], i[7], i[30:25], i[11:8], 1'b0, 19'b0};       im_b = t >>> 19;
        im_u = {i[31:12], 12'b0};
        t = {i[31], i[19:12], i[20], i[30:21], 1'b0, 11'b0};     im_j = t >>> 11;
        d = '0;
        d.rs1 = i[19:15];
        d.rs2 = i[24:20];
        d.rd  = i[11:7];
        d.f3  = i[14:12];
        writer = 1'b0;
        case (i[6:0])
            7'b0110111: begin d.imm = im_u; d.alu = 4'd10; writer = 1'b1; end
            7'b0010111: begin d.imm = im_u; d.alu = 4'd11; writer = 1'b1; end
            7'b1101111: begin d.imm = im_j; d.fu = 2'd1; writer = 1'b1; end
            7'b1100111: begin d.imm = im_i; d.fu = 2'd1; d.u1 = 1'b1; writer = 1'b1; end
            7'b1100011: begin d.imm = im_b; d.fu = 2'd1; d.u1 = 1'b1; d.u2 = 1'b1; end
            7'b0000011: begin d.imm = im_i; d.fu = 2'd2; d.u1 = 1'b1; writer = 1'b1; end
            7'b0100011: begin d.imm = im_s; d.fu = 2'd3; d.u1 = 1'b1; d.u2 = 1'b1; end
            7'b0010011: begin
                d.imm = im_i; d.u1 = 1'b1; writer = 1'b1;
                d.alu = f3_tab[i[14:12]];
                if (i[14:12] == 3'd1 && i[31:25] != 7'd0) d.ill = 1'b1;
                if (i[14:12] == 3'd5 && i[30]) d.alu = 4'd7;
            end
            7'b0110011: begin
                d.u1 = 1'b1; d.u2 = 1'b1; writer = 1'b1;
                d.alu = f3_tab[i[14:12]];
                if (i[31:25] == 7'h20 && i[14:12] == 3'd0) d.alu = 4'd1;
                if (i[31:25] == 7'h20 && i[14:12] == 3'd5) d.alu = 4'd7;
                if (i[31:25] != 7'h00 && i[31:25] != 7'h20) d.ill = 1'b1;
            end
            default: d.ill = 1'b1;
        endcase
        if (d.ill) begin
            d.imm = '0; d.alu = '0; d.fu = '0; d.u1 = 1'b0; d.u2 = 1'b0; writer = 1'b0;
        end
        d.wr = writer && (i[11:7] != 5'd0);
        return d;
    endfunction

    // ---------------- compare process + stage model ----------------
    always @(negedge clk) begin
        logic   exp_rdy;
        logic [W-1:0] e;
        dec_t   m;
        if (!reset) begin
            exp_q.delete();
            check("rst_valid_out", {31'b0, valid_out}, 32'd0);
            check("rst_ready_in", {31'b0, ready_in}, 32'd1);
        end else begin
            exp_rdy = flush || (exp_q.size() == 0) || ready_out;
            check("ready_in", {31'b0, ready_in}, {31'b0, exp_rdy});
            check("valid_out", {31'b0, valid_out}, {31'b0, exp_q.size() != 0});
            if (exp_q.size() != 0 && valid_out) begin
                e = exp_q[0];
                m = ref_decode(e[W-1:PC_W]);
                check("pc_out", {23'b0, pc_out}, {23'b0, e[PC_W-1:0]});
                check("rs1", {27'b0, rs1}, {27'b0, m.rs1});
                check("rs2", {27'b0, rs2}, {27'b0, m.rs2});
                check("rd", {27'b0, rd}, {27'b0, m.rd});
                check("imm", imm, m.imm);
                check("alu_op", {28'b0, alu_op}, {28'b0, m.alu});
                check("fu_type", {30'b0, fu_type}, {30'b0, m.fu});
                check("br_funct3", {29'b0, br_funct3}, {29'b0, m.f3});
                check("mem_funct3", {29'b0, mem_funct3}, {29'b0, m.f3});
                check("flags", {28'b0, uses_rs1, uses_rs2, writes_rd, illegal},
                       {28'b0, m.u1, m.u2, m.wr, m.ill});
            end
            // state after the coming rising edge
            if (flush) begin
                exp_q.delete();
            end else begin
                if (exp_q.size() != 0 && ready_out) begin
                    void'(exp_q.pop_front());
                    emitted++;
                end
                if (valid_in && exp_rdy) exp_q.push_back({instr_in, pc_in});
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic vi, input logic [31:0] ins, input logic [PC_W-1:0] pc,
                         input logic ro, input logic fl);
        valid_in  = vi;
        instr_in  = ins;
        pc_in     = pc;
        ready_out = ro;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] gen_instr();
        logic [6:0]  ops [9];
        logic [31:0] r;
        int          sel;
        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
        r   = $urandom;
        sel = $urandom_range(0, 10);
        if (sel < 9) r[6:0] = ops[sel];
        if (sel == 8 && $urandom_range(0, 7) != 0) r[31:25] = r[30] ? 7'h20 : 7'h00;
        if (sel == 7 && r[14:12] == 3'd1 && $urandom_range(0, 3) != 0) r[31:25] = 7'h00;
        return r;
    endfunction

    // ---------------- directed + random stimulus ----------------
    initial begin
        dec_t m;
        reset = 1'b0; valid_in = 1'b0; instr_in = '0; pc_in = '0;
        ready_out = 1'b0; flush = 1'b0;
        #1;
        check("reset_valid", {31'b0, valid_out}, 32'd0);
        check("reset_ready", {31'b0, ready_in}, 32'd1);
        check("reset_pc", {23'b0, pc_out}, 32'd0);
        check("reset_imm", imm, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // hand-derived values that pin the reference decoder itself
        m = ref_decode(32'hFE000EE3);
        check("model_beq_imm", m.imm, 32'hFFFFFFFC);
        check("model_beq_fu", {30'b0, m.fu}, 32'd1);
        m = ref_decode(32'h40208133);
        check("model_sub_alu", {28'b0, m.alu}, 32'd1);

        // ADDI x1,x0,5
        drive(1'b1, 32'h00500093, 9'h004, 1'b1, 1'b0);
        check("addi_valid", {31'b0, valid_out}, 32'd1);
        check("addi_rd", {27'b0, rd}, 32'd1);
        check("addi_rs1", {27'b0, rs1}, 32'd0);
        check("addi_imm", imm, 32'd5);
        check("addi_alu", {28'b0, alu_op}, 32'd0);
        check("addi_fu", {30'b0, fu_type}, 32'd0);
        check("addi_wr", {31'b0, writes_rd}, 32'd1);
        check("addi_u2", {31'b0, uses_rs2}, 32'd0);
        check("addi_pc", {23'b0, pc_out}, 32'h004);

        // SUB then BEQ back-to-back
        drive(1'b1, 32'h40208133, 9'h008, 1'b1, 1'b0);
        check("sub_valid", {31'b0, valid_out}, 32'd1);
        check("sub_alu", {28'b0, alu_op}, 32'd1);
        check("sub_rd", {27'b0, rd}, 32'd2);
        drive(1'b1, 32'hFE000EE3, 9'h00C, 1'b1, 1'b0);
        check("beq_valid", {31'b0, valid_out}, 32'd1);
        check("beq_fu", {30'b0, fu_type}, 32'd1);
        check("beq_imm", imm, 32'hFFFFFFFC);
        check("beq_pc", {23'b0, pc_out}, 32'h00C);

        // stall three cycles with the BEQ held
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h00000013, 9'h010, 1'b0, 1'b0);
            check("stall_ready_in", {31'b0, ready_in}, 32'd0);
            check("stall_valid", {31'b0, valid_out}, 32'd1);
            check("stall_imm", imm, 32'hFFFFFFFC);
            check("stall_pc", {23'b0, pc_out}, 32'h00C);
        end
        ready_out = 1'b1;
        #1;
        check("release_ready_in", {31'b0, ready_in}, 32'd1);
        @(posedge clk); #1;
        check("nop_pc", {23'b0, pc_out}, 32'h010);
        check("nop_wr", {31'b0, writes_rd}, 32'd0);
        check("nop_ill", {31'b0, illegal}, 32'd0);

        // all-ones encoding
        drive(1'b1, 32'hFFFFFFFF, 9'h014, 1'b1, 1'b0);
        check("ill_flag", {31'b0, illegal}, 32'd1);
        check("ill_wr", {31'b0, writes_rd}, 32'd0);
        check("ill_u1", {31'b0, uses_rs1}, 32'd0);
        check("ill_valid", {31'b0, valid_out}, 32'd1);

        // flush against a held bundle and an arriving instruction
        valid_in = 1'b1; instr_in = 32'h00500093; pc_in = 9'h018;
        ready_out = 1'b0; flush = 1'b1;
        #1;
        check("flush_ready_in", {31'b0, ready_in}, 32'd1);
        @(posedge clk); #1;
        check("flush_valid", {31'b0, valid_out}, 32'd0);
        drive(1'b0, 32'h0, 9'h0, 1'b0, 1'b0);
        check("post_flush_valid", {31'b0, valid_out}, 32'd0);

        // asynchronous reset in the middle of a stall
        drive(1'b1, 32'h00500093, 9'h01C, 1'b0, 1'b0);
        drive(1'b1, 32'h40208133, 9'h020, 1'b0, 1'b0);
        check("pre_reset_pc", {23'b0, pc_out}, 32'h01C);
        #2;
        reset = 1'b0;
        #1;
        check("async_valid", {31'b0, valid_out}, 32'd0);
        check("async_pc", {23'b0, pc_out}, 32'd0);
        check("async_rd", {27'b0, rd}, 32'd0);
        check("async_ready_in", {31'b0, ready_in}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        drive(1'b1, 32'h00500093, 9'h024, 1'b1, 1'b0);
        check("after_reset_valid", {31'b0, valid_out}, 32'd1);
        check("after_reset_imm", imm, 32'd5);
        check("after_reset_pc", {23'b0, pc_out}, 32'h024);

        // random stream with random backpressure and rare flushes
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, gen_instr(), PC_W'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end
        for (int n = 0; n < 3; n++) drive(1'b0, 32'h0, 9'h0, 1'b1, 1'b0);
        check("drain_valid", {31'b0, valid_out}, 32'd0);
        if (emitted < 50) begin
            failures++;
            $display("FAIL emitted_count: got %0d expected at least 50", emitted);
        end
        checks++;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
